// File: rtl/axis_dataout_rx.sv
// AXI4-Stream slave receiver/checker for an incrementing-pattern packet.
// Optional macro AXIS_RX_BACKPRESSURE_EN: LFSR-driven TREADY throttling.
module axis_dataout_rx #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_NUM_WORDS          = 8,
  parameter int C_START_VALUE        = 1,
  parameter int C_STEP               = 1
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              INIT_AXI_RXN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic                              RXN_DONE,
  output logic                              RXN_ERROR,
  output logic [8:0]                        WORD_CNT,
  output logic [7:0]                        ERR_IDX,
  input  logic [7:0]                        BUF_RADDR,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   BUF_RDATA
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int AW = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic           init_q;
  logic           arm;
  logic           ready;
  logic           accept;
  logic           last_k;
  logic           fail;
  logic [W-1:0]   expected;
  logic [W-1:0]   mem [C_NUM_WORDS];
  logic           raddr_ok;

  assign arm      = INIT_AXI_RXN & ~init_q;
  assign last_k   = (WORD_CNT == 9'(C_NUM_WORDS - 1));
  assign accept   = S_AXIS_TVALID & ready & ~arm;
  assign fail     = (S_AXIS_TDATA != expected)
                  | (S_AXIS_TSTRB != '1)
                  | (S_AXIS_TLAST & ~last_k)
                  | (~S_AXIS_TLAST & last_k);
  assign raddr_ok = ({1'b0, BUF_RADDR} < 9'(C_NUM_WORDS));

  assign S_AXIS_TREADY = ready;
  assign RXN_DONE      = (state == DONE);

`ifdef AXIS_RX_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Galois LFSR x^16+x^14+x^13+x^11+1, advancing only while receiving
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      lfsr <= 16'hACE1;
    end else if (state == RECV) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign ready = (state == RECV) & lfsr[0];
`else
  assign ready = (state == RECV);
`endif

  // Arm edge detector register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) init_q <= 1'b0;
    else        init_q <= INIT_AXI_RXN;
  end

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; arming always (re)starts a packet
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (arm) state_nx = RECV;
      RECV: begin
        if (arm)
          state_nx = RECV;
        else if (accept && (S_AXIS_TLAST || last_k))
          state_nx = DONE;
      end
      DONE: if (arm) state_nx = RECV;
      default: state_nx = IDLE;
    endcase
  end

  // Beat counter, expected pattern and first-error capture
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      WORD_CNT  <= '0;
      ERR_IDX   <= '0;
      RXN_ERROR <= 1'b0;
      expected  <= W'(C_START_VALUE);
    end else if (arm) begin
      WORD_CNT  <= '0;
      ERR_IDX   <= '0;
      RXN_ERROR <= 1'b0;
      expected  <= W'(C_START_VALUE);
    end else if (accept) begin
      WORD_CNT <= WORD_CNT + 9'd1;
      expected <= expected + W'(C_STEP);
      if (fail && !RXN_ERROR) begin
        RXN_ERROR <= 1'b1;
        ERR_IDX   <= WORD_CNT[7:0];
      end
    end
  end

  // Capture buffer write port (contents intentionally not reset)
  always_ff @(posedge ACLK) begin
    if (accept) mem[WORD_CNT[AW-1:0]] <= S_AXIS_TDATA;
  end

  // Registered readback; out-of-range addresses read as zero
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)        BUF_RDATA <= '0;
    else if (raddr_ok) BUF_RDATA <= mem[BUF_RADDR[AW-1:0]];
    else               BUF_RDATA <= '0;
  end

endmodule

// File: tb/tb_axis_dataout_rx.sv
// Directed self-checking bench for axis_dataout_rx.
// Runs in the default build or with AXIS_RX_BACKPRESSURE_EN.
module tb_axis_dataout_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        done;
  logic        error;
  logic [8:0]  word_cnt;
  logic [7:0]  err_idx;
  logic [7:0]  raddr;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int low_seen = 0;

  always #5 clk = ~clk;

  axis_dataout_rx dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .INIT_AXI_RXN  (init),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .RXN_DONE      (done),
    .RXN_ERROR     (error),
    .WORD_CNT      (word_cnt),
    .ERR_IDX       (err_idx),
    .BUF_RADDR     (raddr),
    .BUF_RDATA     (rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm();
    init = 1'b1;
    step(1);
    init = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    tstrb  = 4'hF;
    while (!tready && n < 200) begin
      low_seen++;
      step(1);
      n++;
    end
    check("beat_timeout", 32'(n >= 200), 32'd0);
    step(1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic readback(input logic [7:0] a, input logic [31:0] exp,
                          input string tag);
    raddr = a;
    step(1);
    check(tag, rdata, exp);
  endtask

  initial begin
    rst    = 1'b1;
    init   = 1'b0;
    tdata  = '0;
    tstrb  = '0;
    tlast  = 1'b0;
    tvalid = 1'b0;
    raddr  = '0;
    step(3);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_erridx", 32'(err_idx), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    step(2);
    check("idle_tready", 32'(tready), 32'd0);

    // 1: clean packet 1..8
    arm();
    check("t1_tready", 32'(tready), 32'd1);
    for (int k = 0; k < 8; k++) send(32'(k + 1), k == 7);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_cnt", 32'(word_cnt), 32'd8);
    check("t1_tready_off", 32'(tready), 32'd0);
    readback(8'd3, 32'd4, "t1_rd3");
    readback(8'd7, 32'd8, "t1_rd7");
    readback(8'd8, 32'd0, "t1_rd_oob");

    // 2: corrupt beat 5
    arm();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_cnt_clr", 32'(word_cnt), 32'd0);
    for (int k = 0; k < 8; k++)
      send((k == 5) ? 32'hDEAD : 32'(k + 1), k == 7);
    check("t2_done", 32'(done), 32'd1);
    check("t2_error", 32'(error), 32'd1);
    check("t2_erridx", 32'(err_idx), 32'd5);
    check("t2_cnt", 32'(word_cnt), 32'd8);
    readback(8'd5, 32'hDEAD, "t2_rd5");

    // 3: early TLAST on beat 4
    arm();
    check("t3_error_clr", 32'(error), 32'd0);
    for (int k = 0; k < 5; k++) send(32'(k + 1), k == 4);
    check("t3_done", 32'(done), 32'd1);
    check("t3_cnt", 32'(word_cnt), 32'd5);
    check("t3_error", 32'(error), 32'd1);
    check("t3_erridx", 32'(err_idx), 32'd4);
    step(2);
    check("t3_tready", 32'(tready), 32'd0);

    // 4: gapped TVALID with a long stall
    low_seen = 0;
    arm();
    for (int k = 0; k < 4; k++) begin
      send(32'(k + 1), 1'b0);
      step(1);
    end
    step(20);
    check("t4_mid_cnt", 32'(word_cnt), 32'd4);
    check("t4_mid_done", 32'(done), 32'd0);
    for (int k = 4; k < 8; k++) begin
      send(32'(k + 1), k == 7);
      step(1);
    end
    check("t4_done", 32'(done), 32'd1);
    check("t4_error", 32'(error), 32'd0);
    check("t4_cnt", 32'(word_cnt), 32'd8);
`ifdef AXIS_RX_BACKPRESSURE_EN
    check("t4_bp_seen", 32'(low_seen > 0), 32'd1);
`endif

    // 5: reset mid-packet, then full packet
    arm();
    for (int k = 0; k < 3; k++) send(32'(k + 1), 1'b0);
    check("t5_pre_cnt", 32'(word_cnt), 32'd3);
    rst = 1'b1;
    #2;
    check("t5_rst_tready", 32'(tready), 32'd0);
    check("t5_rst_cnt", 32'(word_cnt), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_rdata", rdata, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    arm();
    for (int k = 0; k < 8; k++) send(32'(k + 1), k == 7);
    check("t5_done", 32'(done), 32'd1);
    check("t5_error", 32'(error), 32'd0);
    check("t5_cnt", 32'(word_cnt), 32'd8);

    // 6: beats offered in DONE are held off; long INIT arms once
    tvalid = 1'b1;
    tdata  = 32'd99;
    tstrb  = 4'hF;
    step(3);
    check("t6_bp_tready", 32'(tready), 32'd0);
    check("t6_bp_cnt", 32'(word_cnt), 32'd8);
    tvalid = 1'b0;
    init   = 1'b1;
    step(1);
    tvalid = 1'b1;
    tdata  = 32'd1;
`ifdef AXIS_RX_BACKPRESSURE_EN
    while (!tready) step(1);
`endif
    step(1);
    init   = 1'b0;
    tvalid = 1'b0;
    check("t6_one_arm", 32'(word_cnt), 32'd1);
    for (int k = 1; k < 8; k++) send(32'(k + 1), k == 7);
    check("t6_done", 32'(done), 32'd1);
    check("t6_error", 32'(error), 32'd0);
    check("t6_cnt", 32'(word_cnt), 32'd8);
    readback(8'd0, 32'd1, "t6_rd0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
